// File: rtl/instr_fetch_issue.sv
// rtl/instr_fetch_issue.sv - fetch/issue sequencer feeding controlUnit
//
// Holds the PC, fetches 16-bit instruction words over a req/valid
// handshake and presents Opcode/FunctCode to controlUnit for one ISSUE
// cycle. Resolves jump / branch / sequential next-PC and implements the
// program-stall (0111) and halt (1111) opcodes as sequencer states.
//
// Optional feature macro: MUL_STALL_EN
//   When defined, opcode 0000 with FunctCode 0010 holds Opcode/FunctCode
//   for MUL_CYCLES cycles (issue_valid only in the first), then advances
//   the PC once and returns to FETCH.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request, held until imem_valid
//   imem_addr    out  fetch address (== pc)
//   imem_valid   in   instruction word valid (only honoured in FETCH)
//   imem_data    in   instruction [15:12] op, [11:8] rs, [7:4] rt, [3:0] funct
//   branch_taken in   datapath branch condition, sampled in ISSUE
//   Opcode       out  opcode to controlUnit (0000 outside ISSUE)
//   FunctCode    out  function code to controlUnit (0000 outside ISSUE)
//   issue_valid  out  Opcode/FunctCode carry a real instruction
//   pc           out  current PC
//   halted       out  sequencer halted
//
// ADDR_W must be at least 13: the jump target keeps pc[ADDR_W-1:12].

module instr_fetch_issue #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       STALL_CYCLES = 3,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       MUL_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_data,
    input  logic              branch_taken,
    output logic [3:0]        Opcode,
    output logic [3:0]        FunctCode,
    output logic              issue_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned CNT_MAX = (STALL_CYCLES > MUL_CYCLES) ? STALL_CYCLES : MUL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_STALL  = 4'h7;
    localparam logic [3:0] OP_JUMP   = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_ISSUE = 3'd1,
        S_STALL = 3'd2,
        S_HALT  = 3'd3,
        S_MUL   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [3:0]        funct_q, funct_d;
    logic              issue_valid_q, issue_valid_d;
    logic              imem_req_q, imem_req_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off;

    assign seq_pc = pc_q + ADDR_W'(1);
    assign br_off = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            cnt_q         <= '0;
            opcode_q      <= 4'h0;
            funct_q       <= 4'h0;
            issue_valid_q <= 1'b0;
            // FETCH is the reset state, so the request is already up on
            // the first cycle after release.
            imem_req_q    <= 1'b1;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            cnt_q         <= cnt_d;
            opcode_q      <= opcode_d;
            funct_q       <= funct_d;
            issue_valid_q <= issue_valid_d;
            imem_req_q    <= imem_req_d;
            halted_q      <= halted_d;
        end
    end

    // Next-state logic also computes the *next* value of every output so
    // all outputs come straight from flops.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        cnt_d         = cnt_q;
        opcode_d      = 4'h0;
        funct_d       = 4'h0;
        issue_valid_d = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d          = imem_data;
                    state_d       = S_ISSUE;
                    opcode_d      = imem_data[15:12];
                    funct_d       = imem_data[3:0];
                    issue_valid_d = 1'b1;
                end
            end

            S_ISSUE: begin
                state_d = S_FETCH;
                pc_d    = seq_pc;
                case (ir_q[15:12])
                    OP_JUMP:   pc_d = {pc_q[ADDR_W-1:12], ir_q[11:0]};
                    OP_BRANCH: if (branch_taken) pc_d = seq_pc + br_off;
                    OP_STALL: begin
                        state_d = S_STALL;
                        cnt_d   = CNT_W'(STALL_CYCLES);
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
`ifdef MUL_STALL_EN
                // FP multiply (type-A funct 0010): keep the fields on the
                // bus for the remaining MUL_CYCLES-1 cycles, PC advances
                // only when the hold ends.
                if (ir_q[15:12] == 4'h0 && ir_q[3:0] == 4'h2 && MUL_CYCLES > 1) begin
                    state_d  = S_MUL;
                    cnt_d    = CNT_W'(MUL_CYCLES - 1);
                    pc_d     = pc_q;
                    opcode_d = ir_q[15:12];
                    funct_d  = ir_q[3:0];
                end
`endif
            end

            S_STALL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end

            S_MUL: begin
                opcode_d = ir_q[15:12];
                funct_d  = ir_q[3:0];
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = S_FETCH;
                    pc_d     = seq_pc;
                    cnt_d    = '0;
                    opcode_d = 4'h0;
                    funct_d  = 4'h0;
                end
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase

        imem_req_d = (state_d == S_FETCH);
        halted_d   = (state_d == S_HALT);
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign Opcode      = opcode_q;
    assign FunctCode   = funct_q;
    assign issue_valid = issue_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule
